// File: rtl/quad_decoder_pkg.sv
// Shared encodings and transition classification for the quadrature decoder.
// States are the {A,B} filtered pair; the up order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_decoder_pkg;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_10 = 2'b10;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_01 = 2'b01;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      TR_NONE,
      TR_UP,
      TR_DN,
      TR_BAD
   } trans_t;

   function automatic logic [1:0] next_up(input logic [1:0] s);
      case (s)
         ST_00:   return ST_10;
         ST_10:   return ST_11;
         ST_11:   return ST_01;
         default: return ST_00;
      endcase
   endfunction

   // A down step is an up step read backwards; anything else that moved is a double-bit jump.
   function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
      if (cur == prev)
         return TR_NONE;
      else if (cur == next_up(prev))
         return TR_UP;
      else if (prev == next_up(cur))
         return TR_DN;
      else
         return TR_BAD;
   endfunction

endpackage

// File: rtl/quad_decoder_debounce_filter.sv
// Per-channel two-flop synchronizer followed by a stable-count debounce filter.
// filt follows the synchronized pin only after DEBOUNCE consecutive differing samples.
module debounce_filter #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic sync,
   output logic filt
);

   localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

   logic          s1;
   logic [CW-1:0] stable;

   // Synchronizer runs through reset so the seed below sees live pin levels.
   always_ff @(posedge clk) begin
      s1   <= pin;
      sync <= s1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         filt   <= sync;
         stable <= '0;
      end else if (sync != filt) begin
         if (stable == CW'(DEBOUNCE - 1)) begin
            filt   <= sync;
            stable <= '0;
         end else begin
            stable <= stable + CW'(1);
         end
      end else begin
         stable <= '0;
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: debounced A/B channels drive a wrapping position count,
// a direction flag, a one-cycle step pulse and a sticky illegal-transition flag.
module quad_decoder
   import quad_decoder_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             error
);

   logic       sync_a, sync_b;
   logic       filt_a, filt_b;
   logic [1:0] prev;
   trans_t     tr;

   debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_a (
      .clk   (clk),
      .reset (reset),
      .pin   (a_in),
      .sync  (sync_a),
      .filt  (filt_a)
   );

   debounce_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_b (
      .clk   (clk),
      .reset (reset),
      .pin   (b_in),
      .sync  (sync_b),
      .filt  (filt_b)
   );

   always_comb tr = classify(prev, {filt_a, filt_b});

   // prev seeds from the same synchronized levels as filt, so a resting encoder decodes as no-change.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev  <= {sync_a, sync_b};
         count <= '0;
         dir   <= DIR_UP;
         step  <= 1'b0;
         error <= 1'b0;
      end else begin
         prev <= {filt_a, filt_b};
         step <= (tr == TR_UP) || (tr == TR_DN);
         case (tr)
            TR_UP: begin
               count <= count + WIDTH'(1);
               dir   <= DIR_UP;
            end
            TR_DN: begin
               count <= count - WIDTH'(1);
               dir   <= DIR_DN;
            end
            TR_BAD:  error <= 1'b1;
            default: ;
         endcase
         // clear overrides the count and error updates but leaves step and dir alone.
         if (clear) begin
            count <= '0;
            error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed vector table, hand-written corner sequences and
// randomized pin activity, all checked against a phase-arithmetic reference model.
module tb_quad_decoder;

   localparam int W = 4;
   localparam int D = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         a_in;
   logic         b_in;
   logic         clear;
   logic [W-1:0] count;
   logic         dir;
   logic         step;
   logic         error;

   quad_decoder #(.WIDTH(W), .DEBOUNCE(D)) dut (
      .clk   (clk),
      .reset (reset),
      .a_in  (a_in),
      .b_in  (b_in),
      .clear (clear),
      .count (count),
      .dir   (dir),
      .step  (step),
      .error (error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit       rA[$] = '{1'b0, 1'b0};
   bit       rB[$] = '{1'b0, 1'b0};
   bit       qA[$];
   bit       qB[$];
   bit       m_fa, m_fb;
   bit [1:0] m_prev;
   int       m_count;
   bit       m_dir, m_step, m_err;

   bit [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   typedef struct {
      bit a;
      bit b;
      bit clr;
      int exp_count;
      bit exp_dir;
      bit exp_err;
      int exp_steps;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int phase(input bit [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // One clock edge of the model: decode by quarter-phase distance, then filter.
   task automatic model_edge();
      bit       sA, sB, allA, allB;
      bit [1:0] cur;
      int       d;
      sA = rA[rA.size() - 2];
      sB = rB[rB.size() - 2];
      rA.push_back(a_in);
      rB.push_back(b_in);
      if (rA.size() > 3) rA.delete(0);
      if (rB.size() > 3) rB.delete(0);
      if (reset) begin
         m_fa    = sA;
         m_fb    = sB;
         m_prev  = {sA, sB};
         qA.delete();
         qB.delete();
         m_count = 0;
         m_dir   = 1'b1;
         m_step  = 1'b0;
         m_err   = 1'b0;
      end else begin
         cur    = {m_fa, m_fb};
         d      = (phase(cur) - phase(m_prev) + 4) % 4;
         m_step = 1'b0;
         if (d == 1) begin
            m_count = (m_count + 1) % (1 << W);
            m_dir   = 1'b1;
            m_step  = 1'b1;
         end else if (d == 3) begin
            m_count = (m_count + (1 << W) - 1) % (1 << W);
            m_dir   = 1'b0;
            m_step  = 1'b1;
         end else if (d == 2) begin
            m_err = 1'b1;
         end
         if (clear) begin
            m_count = 0;
            m_err   = 1'b0;
         end
         m_prev = cur;
         qA.push_back(sA);
         qB.push_back(sB);
         if (qA.size() > D) qA.delete(0);
         if (qB.size() > D) qB.delete(0);
         allA = 1'b1;
         allB = 1'b1;
         foreach (qA[i]) if (qA[i] == m_fa) allA = 1'b0;
         foreach (qB[i]) if (qB[i] == m_fb) allB = 1'b0;
         if (qA.size() == D && allA) begin
            m_fa = ~m_fa;
            qA.delete();
         end
         if (qB.size() == D && allB) begin
            m_fb = ~m_fb;
            qB.delete();
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_count", int'(count), m_count);
      chk("model_dir", int'(dir), int'(m_dir));
      chk("model_step", int'(step), int'(m_step));
      chk("model_error", int'(error), int'(m_err));
   endtask

   task automatic hold(input int n, output int steps, output int first);
      steps = 0;
      first = -1;
      for (int c = 0; c < n; c++) begin
         tick();
         clear = 1'b0;
         if (step) begin
            steps++;
            if (first < 0) first = c;
         end
      end
   endtask

   task automatic drive(input bit [1:0] p, input int n);
      int s, f;
      a_in = p[1];
      b_in = p[0];
      hold(n, s, f);
   endtask

   initial begin
      int       steps, first, idx, r, n;
      bit [1:0] p;
      bit       err_seen;

      reset = 1'b1;
      a_in  = 1'b0;
      b_in  = 1'b0;
      clear = 1'b0;
      repeat (4) tick();
      reset = 1'b0;
      chk("rst_count", int'(count), 0);
      chk("rst_dir", int'(dir), 1);
      chk("rst_step", int'(step), 0);
      chk("rst_error", int'(error), 0);

      tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 2,  1'b1, 1'b0, 1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b0, 1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 4,  1'b1, 1'b0, 1});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b0, 0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 0,  1'b1, 1'b1, 0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, 0});

      foreach (tbl[i]) begin
         a_in  = tbl[i].a;
         b_in  = tbl[i].b;
         clear = tbl[i].clr;
         hold(8, steps, first);
         chk($sformatf("vec%0d_count", i), int'(count), tbl[i].exp_count);
         chk($sformatf("vec%0d_dir", i), int'(dir), int'(tbl[i].exp_dir));
         chk($sformatf("vec%0d_error", i), int'(error), int'(tbl[i].exp_err));
         chk($sformatf("vec%0d_steps", i), steps, tbl[i].exp_steps);
         if (tbl[i].exp_steps == 1)
            chk($sformatf("vec%0d_latency", i), first, D + 2);
      end

      // Short glitch on A (2 cycles, under the debounce length) must be ignored.
      a_in = 1'b0;
      hold(2, steps, first);
      chk("glitch_steps_low", steps, 0);
      a_in = 1'b1;
      hold(8, steps, first);
      chk("glitch_steps", steps, 0);
      chk("glitch_count", int'(count), 0);
      chk("glitch_dir", int'(dir), 1);

      // Reset while the encoder rests at 11: seeding must avoid a spurious step or error.
      reset = 1'b1;
      hold(3, steps, first);
      reset = 1'b0;
      err_seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (error || step) err_seen = 1'b1;
      end
      chk("seed11_quiet", int'(err_seen), 0);
      drive(2'b01, 8);
      chk("seed11_count", int'(count), 1);
      chk("seed11_dir", int'(dir), 1);
      chk("seed11_error", int'(error), 0);

      // Walk up to count 7, then collide clear with the next up step.
      drive(2'b00, 8);
      drive(2'b10, 8);
      drive(2'b11, 8);
      drive(2'b01, 8);
      drive(2'b00, 8);
      drive(2'b10, 8);
      chk("pre_clear_count", int'(count), 7);
      a_in = 1'b1;
      b_in = 1'b1;
      repeat (D + 2) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_step_count", int'(count), 0);
      chk("clr_step_step", int'(step), 1);
      chk("clr_step_dir", int'(dir), 1);
      repeat (4) tick();

      // Randomized activity, including too-fast edges, glitches, clears and resets.
      for (int s = 0; s < 90; s++) begin
         p = {a_in, b_in};
         idx = phase(p);
         r = $urandom_range(0, 11);
         n = $urandom_range(1, 9);
         if (r <= 3) begin
            drive(seq[(idx + 1) % 4], n);
         end else if (r <= 6) begin
            drive(seq[(idx + 3) % 4], n);
         end else if (r == 7) begin
            drive(seq[(idx + 2) % 4], n);
         end else if (r == 8) begin
            drive(p ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01), $urandom_range(1, 3));
            drive(p, n);
         end else if (r == 9) begin
            clear = 1'b1;
            drive(p, n);
         end else if (r == 10) begin
            reset = 1'b1;
            drive(p, $urandom_range(2, 3));
            reset = 1'b0;
            drive(p, n);
         end else begin
            drive(p, n);
         end
      end
      repeat (D + 4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
